// File: rtl/waverv_pkg.sv
// waverv_pkg: shared definitions for the waverv control path.
//   - RV32I major opcodes handled by the decoder
//   - ALU operation encodings driven onto `operation`
//   - instruction classes and the decoder result struct
//   - sequencer state encodings (plain constants, legacy-compatible)
//   - program_counter_source / writeback_select encodings
package waverv_pkg;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  // SYSTEM (ECALL/EBREAK/CSR) is deliberately absent: it decodes as illegal.

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic         legal;
    alu_op_e      op;
    logic         imm_en;
  } dec_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_MEMORY    = 3'd4;
  localparam state_t ST_WRITEBACK = 3'd5;
  localparam state_t ST_TRAP      = 3'd6;

  localparam logic [1:0] PCS_PLUS4 = 2'd0;
  localparam logic [1:0] PCS_IMM   = 2'd1;
  localparam logic [1:0] PCS_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // funct3 -> ALU op; `alt` selects SUB/SRA (instruction bit 30).
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: single shared memory port handshake.
//   mem_request        sequencer -> memory  access pending
//   mem_write          sequencer -> memory  1 = store, 0 = read
//   mem_address_select sequencer -> memory  0 = PC, 1 = alu_out
//   mem_ready          memory -> sequencer  pending request completes this cycle
interface control_sequencer_if;
  logic mem_request;
  logic mem_write;
  logic mem_address_select;
  logic mem_ready;

  modport master (output mem_request, mem_write, mem_address_select, input mem_ready);
  modport slave  (input mem_request, mem_write, mem_address_select, output mem_ready);
endinterface

// File: rtl/control_decoder.sv
// control_decoder: combinational RV32I instruction classifier.
//   instruction  in   instruction register contents
//   dec          out  class, legality, ALU op and immediate-operand enable
module control_decoder
  import waverv_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];
  // register specifiers and immediates belong to the datapath
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    dec = '{cls: CL_ILLEGAL, legal: 1'b0, op: ALU_ADD, imm_en: 1'b1};
    case (opcode)
      OPC_OP: begin
        dec.cls    = CL_OP;
        dec.imm_en = 1'b0;
        dec.op     = alu_from_funct(f3, f7[5]);
        // 0100000 only encodes SUB and SRA
        dec.legal  = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OPIMM: begin
        dec.cls   = CL_OPIMM;
        dec.legal = 1'b1;
        // bit 30 is immediate data except for shift-right, where it picks SRAI
        dec.op    = alu_from_funct(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_LOAD: begin
        dec.cls   = CL_LOAD;
        dec.legal = !(f3 == 3'b011 || f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.cls   = CL_STORE;
        dec.legal = (f3 <= 3'b010);
      end
      OPC_BRANCH: begin
        dec.cls    = CL_BRANCH;
        dec.imm_en = 1'b0;
        dec.op     = ALU_SUB;
        dec.legal  = (f3[2:1] != 2'b01);
      end
      OPC_JAL:     begin dec.cls = CL_JAL;   dec.legal = 1'b1; end
      OPC_JALR:    begin dec.cls = CL_JALR;  dec.legal = 1'b1; end
      OPC_LUI:     begin dec.cls = CL_LUI;   dec.legal = 1'b1; end
      OPC_AUIPC:   begin dec.cls = CL_AUIPC; dec.legal = 1'b1; end
      OPC_MISCMEM: begin dec.cls = CL_FENCE; dec.legal = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM for the waverv RV32I core.
//   clk, rst               clock; synchronous active-high reset
//   bus (master)           shared memory port request/ready handshake
//   instruction            instruction register, valid from DECODE on
//   branch_taken           comparator result, valid in EXECUTE
//   instruction_load       capture fetched word
//   program_counter_write/_source, register_write_enable, writeback_select
//   alu_immediate_enable, operation   ALU control
//   instruction_retired    one pulse per completed instruction
//   trap                   sticky; cleared only by rst
// Parameters: MEM_TIMEOUT cycles without mem_ready before trapping (0 = never),
// TIMEOUT_WIDTH width of the wait counter.
module control_sequencer
  import waverv_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int TIMEOUT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus,
  input  logic [31:0]         instruction,
  input  logic                branch_taken,
  output logic                instruction_load,
  output logic                program_counter_write,
  output logic [1:0]          program_counter_source,
  output logic                register_write_enable,
  output logic [1:0]          writeback_select,
  output logic                alu_immediate_enable,
  output logic [3:0]          operation,
  output logic                instruction_retired,
  output logic                trap
);
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST =
    TIMEOUT_WIDTH'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                   state, state_nxt;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     waiting, timed_out;
  dec_t                     dec;

  control_decoder u_dec (
    .instruction (instruction),
    .dec         (dec)
  );

  assign waiting   = (state == ST_FETCH) || (state == ST_MEMORY);
  // the last permitted cycle still completes if mem_ready arrives in it
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST) && !bus.mem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  state_nxt = ST_DECODE;
        else if (timed_out) state_nxt = ST_TRAP;
      end
      ST_DECODE: state_nxt = dec.legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        case (dec.cls)
          CL_BRANCH, CL_FENCE: state_nxt = ST_FETCH;
          CL_LOAD, CL_STORE:   state_nxt = ST_MEMORY;
          default:             state_nxt = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (bus.mem_ready)  state_nxt = (dec.cls == CL_LOAD) ? ST_WRITEBACK : ST_FETCH;
        else if (timed_out) state_nxt = ST_TRAP;
      end
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_TRAP:      state_nxt = ST_TRAP;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // every entry into a memory-wait state starts a fresh count
      if (state_nxt != state && (state_nxt == ST_FETCH || state_nxt == ST_MEMORY))
        wait_cnt <= '0;
      else if (waiting && !bus.mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.mem_request        = 1'b0;
    bus.mem_write          = 1'b0;
    bus.mem_address_select = 1'b0;
    instruction_load       = 1'b0;
    program_counter_write  = 1'b0;
    program_counter_source = PCS_PLUS4;
    register_write_enable  = 1'b0;
    writeback_select       = WB_ALU;
    alu_immediate_enable   = 1'b0;
    operation              = ALU_ADD;
    instruction_retired    = 1'b0;
    trap                   = 1'b0;

    // ALU control stays up through MEMORY (address) and WRITEBACK
    // (JALR target and OP results are taken from alu_out there)
    if (state == ST_EXECUTE || state == ST_MEMORY || state == ST_WRITEBACK) begin
      operation            = dec.op;
      alu_immediate_enable = dec.imm_en;
    end

    case (state)
      ST_FETCH: begin
        bus.mem_request  = 1'b1;
        instruction_load = bus.mem_ready;
      end
      ST_EXECUTE: begin
        if (dec.cls == CL_BRANCH || dec.cls == CL_FENCE) begin
          program_counter_write = 1'b1;
          instruction_retired   = 1'b1;
          if (dec.cls == CL_BRANCH && branch_taken) program_counter_source = PCS_IMM;
        end
      end
      ST_MEMORY: begin
        bus.mem_request        = 1'b1;
        bus.mem_address_select = 1'b1;
        bus.mem_write          = (dec.cls == CL_STORE);
        if (dec.cls == CL_STORE && bus.mem_ready) begin
          program_counter_write = 1'b1;
          instruction_retired   = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        register_write_enable = 1'b1;
        program_counter_write = 1'b1;
        instruction_retired   = 1'b1;
        case (dec.cls)
          CL_LOAD:         writeback_select = WB_MEM;
          CL_JAL, CL_JALR: writeback_select = WB_PC4;
          CL_LUI:          writeback_select = WB_IMM;
          default:         writeback_select = WB_ALU;
        endcase
        if (dec.cls == CL_JAL)       program_counter_source = PCS_IMM;
        else if (dec.cls == CL_JALR) program_counter_source = PCS_ALU;
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end
endmodule
